encrypt_seq_ctrl: RTL and testbench

//  Sequencer for the lift / polynomialmultiplication / Add_in_Rq / pack_Rq0 datapath.

---
 rtl/encrypt_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_encrypt_seq_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/encrypt_seq_ctrl.sv
// encrypt_seq_ctrl: sequencer for the lift / polynomial multiplication /
// Add_in_Rq / pack_Rq0 datapath. It accepts one job per start/ready handshake,
// pulses ld_in to capture the operands, and holds en_lift and en_poly high for
// their cycle counts. It then waits for the add/pack path to settle, pulses
// ld_out to capture c2, and pulses done.
//
// Optional feature: define ENC_CTRL_PERF_EN to add the cycle_cnt port, which
// reports how many busy cycles the last completed job took.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous reset, active-high
//   start      in   job request, sampled only in IDLE
//   abort      in   cancel the current job (LOAD..CAPTURE)
//   ready      out  1 in IDLE only
//   busy       out  1 in any state other than IDLE
//   ld_in      out  1-cycle operand capture pulse
//   en_lift    out  lift enable
//   en_poly    out  polynomial multiplier enable
//   ld_out     out  1-cycle result capture pulse
//   done       out  1-cycle result-valid pulse
//   cycle_cnt  out  [15:0] busy cycles of last completed job (ENC_CTRL_PERF_EN only)
module encrypt_seq_ctrl #(
    parameter int unsigned POLY_CYCLES   = 701,
    parameter int unsigned LIFT_CYCLES   = 3,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        ready,
    output logic        busy,
    output logic        ld_in,
    output logic        en_lift,
    output logic        en_poly,
    output logic        ld_out,
    output logic        done
`ifdef ENC_CTRL_PERF_EN
    ,
    output logic [15:0] cycle_cnt
`endif
);

    localparam int unsigned RUN_CYCLES = (POLY_CYCLES > LIFT_CYCLES) ? POLY_CYCLES : LIFT_CYCLES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] run_idx_n;
    logic             ld_in_n, en_lift_n, en_poly_n, ld_out_n, done_n;

    // Next-state and next-output logic; all outputs are registered from these.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ld_in_n   = 1'b0;
        en_lift_n = 1'b0;
        en_poly_n = 1'b0;
        ld_out_n  = 1'b0;
        done_n    = 1'b0;
        // Zero-based index of the next RUN cycle; cnt counts remaining RUN cycles minus one.
        run_idx_n = CNT_W'(RUN_CYCLES) - cnt;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_LOAD;
                    ld_in_n = 1'b1;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else begin
                    state_n   = S_RUN;
                    cnt_n     = CNT_W'(RUN_CYCLES - 1);
                    en_poly_n = (POLY_CYCLES != 0);
                    en_lift_n = (LIFT_CYCLES != 0);
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else if (cnt == '0) begin
                    if (SETTLE_CYCLES != 0) begin
                        state_n = S_SETTLE;
                        cnt_n   = CNT_W'(SETTLE_CYCLES - 1);
                    end else begin
                        state_n  = S_CAPTURE;
                        ld_out_n = 1'b1;
                    end
                end else begin
                    cnt_n     = cnt - CNT_W'(1);
                    en_poly_n = (run_idx_n < CNT_W'(POLY_CYCLES));
                    en_lift_n = (run_idx_n < CNT_W'(LIFT_CYCLES));
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else if (cnt == '0) begin
                    state_n  = S_CAPTURE;
                    ld_out_n = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end
            end
            S_DONE: begin
                // abort is ignored here so that done always pulses.
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            ld_in   <= 1'b0;
            en_lift <= 1'b0;
            en_poly <= 1'b0;
            ld_out  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ready   <= (state_n == S_IDLE);
            busy    <= (state_n != S_IDLE);
            ld_in   <= ld_in_n;
            en_lift <= en_lift_n;
            en_poly <= en_poly_n;
            ld_out  <= ld_out_n;
            done    <= done_n;
        end
    end

`ifdef ENC_CTRL_PERF_EN
    // job_cnt accumulates the running job; cycle_cnt publishes it only on
    // reaching DONE, so an aborted job leaves the last completed value intact.
    logic [15:0] job_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            job_cnt   <= '0;
            cycle_cnt <= '0;
        end else begin
            if (state == S_IDLE && state_n == S_LOAD) begin
                job_cnt <= 16'd1;
            end else if (state_n != S_IDLE && job_cnt != 16'hFFFF) begin
                job_cnt <= job_cnt + 16'd1;
            end
            if (state_n == S_DONE) begin
                cycle_cnt <= (job_cnt == 16'hFFFF) ? job_cnt : job_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_encrypt_seq_ctrl.sv
// Testbench for encrypt_seq_ctrl. A reference model predicts every output
// each cycle; expected done cycles are queued when a job is accepted and
// compared when the DUT pulses done. A second instance with short parameters
// covers the LIFT > POLY, zero-settle case.
module tb_encrypt_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, abort;
    logic ready, busy, ld_in, en_lift, en_poly, ld_out, done;
`ifdef ENC_CTRL_PERF_EN
    logic [15:0] cycle_cnt;
    logic [15:0] cycle_cnt2;
`endif

    logic rst2, start2, abort2;
    logic ready2, busy2, ld_in2, en_lift2, en_poly2, ld_out2, done2;

    logic [6:0] outs, outs2;
    assign outs  = {ready, busy, ld_in, en_lift, en_poly, ld_out, done};
    assign outs2 = {ready2, busy2, ld_in2, en_lift2, en_poly2, ld_out2, done2};

    encrypt_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ready(ready), .busy(busy), .ld_in(ld_in), .en_lift(en_lift),
        .en_poly(en_poly), .ld_out(ld_out), .done(done)
`ifdef ENC_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt)
`endif
    );

    encrypt_seq_ctrl #(
        .POLY_CYCLES(4), .LIFT_CYCLES(6), .SETTLE_CYCLES(0), .CNT_W(4)
    ) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .abort(abort2),
        .ready(ready2), .busy(busy2), .ld_in(ld_in2), .en_lift(en_lift2),
        .en_poly(en_poly2), .ld_out(ld_out2), .done(done2)
`ifdef ENC_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt2)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit armed   = 1'b0;
    bit job_on  = 1'b0;
    int job_t   = 0;
    int done_seen = 0;
    int q_done[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected {ready,busy,ld_in,en_lift,en_poly,ld_out,done} rel cycles after start was sampled.
    function automatic logic [6:0] exp_outs(input int p, input int l, input int s, input int rel);
        int r;
        logic b;
        r = (p > l) ? p : l;
        b = (rel >= 1) && (rel <= 3 + r + s);
        return {!b, b, rel == 1, (rel >= 2) && (rel <= 1 + l), (rel >= 2) && (rel <= 1 + p),
                rel == 2 + r + s, rel == 3 + r + s};
    endfunction

    // Reference model: samples inputs at each posedge (cycle cyc's inputs).
    always @(posedge clk) begin
        int rel;
        bit active;
        rel    = cyc - job_t;
        active = job_on && (rel <= 706);
        if (rst) begin
            if (active && rel <= 705 && q_done.size() > 0) void'(q_done.pop_back());
            job_on = 1'b0;
            armed  = 1'b1;
        end else if (active) begin
            if (abort && rel <= 705) begin
                if (q_done.size() > 0) void'(q_done.pop_back());
                job_on = 1'b0;
            end
        end else if (start) begin
            job_on = 1'b1;
            job_t  = cyc;
            q_done.push_back(cyc + 706);
        end
        cyc = cyc + 1;
    end

    // Per-cycle output comparison and done scoreboard.
    always @(negedge clk) begin
        int rel;
        if (armed) begin
            rel = job_on ? (cyc - job_t) : 0;
            check("outs", 32'(outs), 32'(exp_outs(701, 3, 2, rel)));
            if (done) begin
                done_seen++;
                if (q_done.size() == 0) check("done_unexpected", 1, 0);
                else check("done_cycle", cyc, q_done.pop_front());
            end
        end
    end

    task automatic start_job(output int s);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output int rc);
        rc = -1;
        for (int i = 0; i < 3000; i++) begin
            if (ready) begin
                rc = cyc;
                return;
            end
            @(negedge clk);
        end
        check("idle_timeout", 0, 1);
    endtask

    task automatic go_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s2, rc, d0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        rst2 = 1'b1; start2 = 1'b0; abort2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; rst2 = 1'b0;

        // T5: short parameters, start at local cycle 0.
        check("t5_reset", 32'(outs2), 32'(exp_outs(4, 6, 0, 0)));
        start2 = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            check($sformatf("t5_c%0d", k), 32'(outs2), 32'(exp_outs(4, 6, 0, k)));
        end

        // T1: single job with default parameters.
        start_job(s);
        wait_idle(rc);
        check("t1_ready_cycle", rc, s + 707);
`ifdef ENC_CTRL_PERF_EN
        check("t1_cycle_cnt", 32'(cycle_cnt), 706);
`endif

        // T2: start held high for 2000 cycles.
        d0 = done_seen;
        start = 1'b1;
        repeat (2000) @(negedge clk);
        start = 1'b0;
        wait_idle(rc);
        check("t2_jobs", done_seen - d0, 3);

        // T3: abort at RUN cycle 100, then a normal job.
        start_job(s);
        go_to(s + 101);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t3_ready", 32'(ready), 1);
        check("t3_en_poly", 32'(en_poly), 0);
`ifdef ENC_CTRL_PERF_EN
        check("t3_cycle_cnt_hold", 32'(cycle_cnt), 706);
`endif
        start_job(s);
        wait_idle(rc);
        check("t3_ready_cycle", rc, s + 707);

        // T4: reset during SETTLE, then full-latency job.
        start_job(s);
        go_to(s + 703);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_ready", 32'(ready), 1);
`ifdef ENC_CTRL_PERF_EN
        check("t4_cycle_cnt_clr", 32'(cycle_cnt), 0);
`endif
        start_job(s);
        wait_idle(rc);
        check("t4_ready_cycle", rc, s + 707);
`ifdef ENC_CTRL_PERF_EN
        check("t4_cycle_cnt", 32'(cycle_cnt), 706);
`endif

        // T7: start+abort in the DONE cycle are ignored; start+abort in IDLE starts a job.
        start_job(s);
        go_to(s + 706);
        d0 = done_seen;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("t7_done_in_done", done_seen - d0, 1);
        check("t7_no_restart", 32'(busy), 0);
        start = 1'b1;
        abort = 1'b1;
        s2 = cyc;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("t7_accept", 32'(ld_in), 1);
        wait_idle(rc);
        check("t7_ready_cycle", rc, s2 + 707);

        repeat (3) @(negedge clk);
        check("q_empty", q_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
